fifo_rd_drainer: RTL

//  Read-side consumer of the async FIFO. It lives in the rd_clk domain.
//  - Issues rd_en against fifo_empty.
//  - Captures data_out after the FIFO read latency.
//  - Re-presents each word on a valid/ready stream toward downstream logic.
//  - Credit-limited so that no word is ever dropped under backpressure.

---
 rtl/fifo_rd_drainer_if.sv | 48 ++++
 rtl/fifo_rd_drainer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drainer_if.sv
// ----------------------------------------------------------------------------
// fifo_rd_drainer_if
//   Groups the FIFO read-side signals and the downstream valid/ready stream
//   used by fifo_rd_drainer.
//
//   FIFO side
//     rd_en              read strobe toward the async FIFO
//     fifo_empty         FIFO empty flag (rd_clk domain)
//     fifo_almost_empty  FIFO almost-empty flag (rd_clk domain)
//     data_out           FIFO read data, valid RD_LAT cycles after rd_en
//   Stream side
//     m_valid / m_data   output word and its qualifier
//     m_ready            downstream accept
//
//   master : the drainer (drives rd_en and the m_* stream)
//   slave  : the FIFO plus the downstream consumer
// ----------------------------------------------------------------------------
interface fifo_rd_drainer_if #(
    parameter int DW = 32
);
    logic          rd_en;
    logic          fifo_empty;
    logic          fifo_almost_empty;
    logic [DW-1:0] data_out;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    modport master (
        output rd_en,
        output m_valid,
        output m_data,
        input  fifo_empty,
        input  fifo_almost_empty,
        input  data_out,
        input  m_ready
    );

    modport slave (
        input  rd_en,
        input  m_valid,
        input  m_data,
        output fifo_empty,
        output fifo_almost_empty,
        output data_out,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_drainer.sv
// ----------------------------------------------------------------------------
// fifo_rd_drainer
//   Read-side consumer of an async FIFO, entirely in the rd_clk domain.
//   Issues reads while credits remain, captures the read data RD_LAT cycles
//   later into a small output buffer, and re-presents each word on a
//   valid/ready stream. Credits = OBUF_DEPTH - (buffered + in-flight words),
//   so a captured word always has a slot and nothing is dropped under
//   backpressure.
//
// Parameters
//   DW          data width
//   RD_LAT      rd_clk cycles from rd_en to data_out valid (1..3)
//   OBUF_DEPTH  output buffer entries (power of 2, >= RD_LAT+1)
//
// Ports
//   rd_clk    in   read clock
//   reset     in   asynchronous active-low reset
//   enable    in   1 = drain the FIFO, 0 = stop issuing reads and flush
//   bus       --   fifo_rd_drainer_if.master (rd_en, fifo flags, data_out,
//                  m_valid, m_data, m_ready)
//   rd_count  out  words delivered on the stream since reset (wraps)
//   busy      out  high whenever the controller is not IDLE
// ----------------------------------------------------------------------------
module fifo_rd_drainer #(
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int OBUF_DEPTH = 4
) (
    input  logic              rd_clk,
    input  logic              reset,
    input  logic              enable,
    fifo_rd_drainer_if.master bus,
    output logic [31:0]       rd_count,
    output logic              busy
);

    localparam int AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    // One spare bit so occ + inflight + a new read never overflows.
    localparam int CW = $clog2(OBUF_DEPTH + 1) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(OBUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t            state_reg;
    logic              busy_reg;
    logic [AW-1:0]     head_reg;
    logic [AW-1:0]     tail_reg;
    logic [CW-1:0]     occ_reg;
    logic [RD_LAT-1:0] pipe_reg;
    logic [31:0]       rd_count_reg;

    logic [CW-1:0]     inflight;
    logic [CW-1:0]     used_cnt;
    logic [CW-1:0]     used_next;
    logic              rd_en_int;
    logic              capture;
    logic              pop;
    logic              m_valid_int;
    logic [DW-1:0]     mem_rd [OBUF_DEPTH];

    // ------------------------------------------------------------------
    // Credit accounting
    // ------------------------------------------------------------------
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(pipe_reg[i]);
        end
    end

    assign used_cnt    = occ_reg + inflight;
    assign capture     = pipe_reg[RD_LAT-1];
    assign m_valid_int = (occ_reg != '0);
    assign pop         = m_valid_int & bus.m_ready;
    assign used_next   = used_cnt + CW'(rd_en_int) - CW'(pop);

    // Near empty, only one read may be outstanding so the FIFO flags always
    // reflect every read already issued.
    // reset is part of the term so the strobe is low for the whole reset
    // pulse, not only from the next clock edge.
    assign rd_en_int = reset
                     & (state_reg == READ)
                     & enable
                     & ~bus.fifo_empty
                     & (used_cnt < DEPTH_C)
                     & (~bus.fifo_almost_empty | (inflight == '0));

    assign bus.rd_en = rd_en_int;

    // ------------------------------------------------------------------
    // Read-latency shift pipe: bit i set means a read issued i+1 cycles ago
    // ------------------------------------------------------------------
    always_ff @(posedge rd_clk or negedge reset) begin
        if (!reset) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg[0] <= rd_en_int;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output buffer storage, one register word per entry
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < OBUF_DEPTH; gi++) begin : g_word
        logic [DW-1:0] word_reg;

        always_ff @(posedge rd_clk or negedge reset) begin
            if (!reset) begin
                word_reg <= '0;
            end else if (capture && (tail_reg == AW'(gi))) begin
                word_reg <= bus.data_out;
            end
        end

        assign mem_rd[gi] = word_reg;
    end

    // Pointers wrap naturally because OBUF_DEPTH is a power of two.
    always_ff @(posedge rd_clk or negedge reset) begin
        if (!reset) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            occ_reg      <= '0;
            rd_count_reg <= '0;
        end else begin
            if (capture) begin
                tail_reg <= tail_reg + AW'(1);
            end
            if (pop) begin
                head_reg     <= head_reg + AW'(1);
                rd_count_reg <= rd_count_reg + 32'd1;
            end
            if (capture && !pop) begin
                occ_reg <= occ_reg + CW'(1);
            end else if (!capture && pop) begin
                occ_reg <= occ_reg - CW'(1);
            end
        end
    end

    // m_data reads as zero while the buffer is empty.
    assign bus.m_valid = m_valid_int;
    assign bus.m_data  = m_valid_int ? mem_rd[head_reg] : '0;
    assign rd_count    = rd_count_reg;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge rd_clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg <= READ;
                        busy_reg  <= 1'b1;
                    end
                end
                READ: begin
                    if (!enable) begin
                        state_reg <= FLUSH;
                    end else if (used_next == DEPTH_C) begin
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (!enable) begin
                        state_reg <= FLUSH;
                    end else if (used_next < DEPTH_C) begin
                        state_reg <= READ;
                    end
                end
                FLUSH: begin
                    // Words already read are always delivered before IDLE.
                    if (enable) begin
                        state_reg <= READ;
                    end else if ((inflight == '0) && (occ_reg == '0)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;

    // A capture into a full buffer would mean the credit rule is broken.
    a_no_overflow : assert property (@(posedge rd_clk) disable iff (!reset)
        !(capture && !pop && (occ_reg == DEPTH_C)));

endmodule
